n8_pad_reader: RTL and testbench
================================

# n8_pad_reader

Upstream of the cursor/selection decoder: polls the N8 (NES-style) serial gamepad over `latch`/`pulse`/`data_in` at a fixed rate. It deserializes the 8 active-low button bits and requires two consecutive frames to agree before accepting them (frame-to-frame debounce). It presents a stable held-button vector plus one-cycle press strobes (`up`, `down`, `select`, `start`) that feed the decoder and the game-reset path directly.

## Interface
- `LATCH_CYCLES`, default 600: cycles `latch` is held high per frame (12 us at 50 MHz).
- `HALF_CYCLES`, default 300: cycles per `pulse` high or low phase (6 us).
- `POLL_CYCLES`, default 833_333: frame start-to-start period (60 Hz). Must exceed `LATCH_CYCLES + 15*HALF_CYCLES + 1`; checked by elaboration assertion.
- `clk`, input, 1: CLOCK_50.
- `reset`, input, 1: synchronous, active-high.
- `data_in`, input, 1: pad serial data, asynchronous, active-low.
- `latch`, output, 1: pad parallel-load strobe.
- `pulse`, output, 1: pad shift clock.
- `buttons`, output, 8: debounced held state, active-high. Bit order: A, B, Select, Start, Up, Down, Left, Right = bits 0..7.
- `press`, output, 8: one-cycle rising-edge strobes of `buttons`.
- `up`, `down`, `select`, `start`, output, 1 each: aliases of `press[4]`, `press[5]`, `press[2]`, `press[3]`.
- `frame_done`, output, 1: one-cycle strobe at the end of every frame.

## Operation
- `data_in` passes through a 2-FF synchronizer before sampling.
- Per-frame state sequence:
  - IDLE: wait for the poll counter to expire.
  - LATCH: `latch`=1 for `LATCH_CYCLES` cycles.
  - READ: bits k=0..7 in order.
    - k=0: `pulse`=0 for `HALF_CYCLES`.
    - k≥1: `pulse`=1 for `HALF_CYCLES`, then `pulse`=0 for `HALF_CYCLES`.
    - Bit k is sampled as the inverted synchronized `data_in` in the last cycle of its low phase. Bit 0 is shifted in first and lands in `raw[0]`.
  - DONE: one cycle, then back to IDLE.
- Exactly 7 `pulse` high phases per frame; `latch` and `pulse` are never high together.
- At the DONE edge:
  - If `raw == prev_raw`, then `buttons <= raw` and `press <= raw & ~buttons`; otherwise `buttons` holds and `press <= 0`.
  - `prev_raw <= raw` in both cases.
  - `frame_done <= 1`.
- `press` and `frame_done` are high for exactly one cycle per frame. A held button produces one press only.
- Release needs two agreeing frames as well. Release never strobes `press`.
- All outputs are registered.

## Timing
- Reset values: `latch`=0, `pulse`=0, `buttons`=0, `press`=0, `frame_done`=0. Internal state: `prev_raw`=0, state IDLE, poll counter expired.
- The first frame's LATCH begins the cycle after `reset` deasserts.
- Frame starts are exactly `POLL_CYCLES` apart, counted from LATCH entry.
- Latency from the last sample cycle to outputs: DONE occupies 1 cycle, and `press`/`frame_done` are visible the cycle after DONE (2 cycles total).
- Frame length is `LATCH_CYCLES + 15*HALF_CYCLES + 1` cycles.
- `reset` mid-frame:
  - Abort immediately; `latch`/`pulse` go low the next cycle.
  - The partial frame is discarded and nothing is strobed.
  - `buttons` is cleared.
- All 8 pressed, or none, are legal patterns with no special casing.
- A change of pad state within a frame is simply captured per bit at its sample instant.
- Counters are sized with `$clog2` of their parameter. The poll counter wraps only through reload at frame start.

## Structure
- Package `n8_pkg`:
  - Button index constants `BTN_A`=0 … `BTN_RIGHT`=7.
  - Phase enum `n8_state_t` {IDLE, LATCH, READ, DONE}.
- Sub-module `sync2` (2-FF synchronizer for `data_in`). Everything else lives in one FSM plus two counters (phase timer, poll timer) and an 8-bit shift register.

## Test plan
All tests use `LATCH_CYCLES`=4, `HALF_CYCLES`=2, `POLL_CYCLES`=64, with a behavioural pad model: 8-bit shift register loaded on `latch`, shifted on `pulse` rising edge, output inverted.

- Reset, then release:
  - `latch` high for cycles 1–4 after release.
  - Exactly 7 `pulse` highs of 2 cycles each.
  - `frame_done` exactly at cycle 36 after release.
  - Next `latch` rises at cycle 65.
- Pad holds Up (bit 4) across frames:
  - Frame 1: `buttons`=0, no press.
  - Frame 2: `buttons`=8'h10, `up` high for one cycle.
  - Frame 3: `buttons`=8'h10, `up`=0.
- Bit order: pad pattern 8'b1010_0101 held for 2 frames.
  - `buttons`=8'hA5.
  - `select`=1 and `start`=0 in the strobe cycle.
- Glitch: Start asserted for only one frame between idle frames.
  - `buttons` stays 0, `start` never pulses.
  - Release of Up after two idle frames clears bit 4 with no strobe.
- Reset asserted while in READ at bit 3:
  - Next cycle `latch`=`pulse`=0 and `buttons`=0.
  - No `frame_done`.
  - A fresh frame starts the cycle after deassert.
- Throughout all runs:
  - Assert `latch` and `pulse` are never high together.
  - Assert `press` is never nonzero without `frame_done`.

Source files
------------

// File: rtl/n8_pkg.sv
// Shared constants and phase encoding for the N8 serial gamepad reader.
package n8_pkg;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        READ,
        DONE
    } n8_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer; resets to 1, the idle level of an active-low pad line.
module sync2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/n8_pad_reader.sv
// Polls an N8 serial pad at a fixed rate, debounces across two agreeing frames,
// and presents held buttons plus one-cycle press strobes.
module n8_pad_reader
    import n8_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES = 600,
    parameter int unsigned HALF_CYCLES  = 300,
    parameter int unsigned POLL_CYCLES  = 833_333
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic       latch,
    output logic       pulse,
    output logic [7:0] buttons,
    output logic [7:0] press,
    output logic       up,
    output logic       down,
    output logic       select,
    output logic       start,
    output logic       frame_done
);

    localparam int unsigned TMax = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;
    localparam int unsigned PW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [TW-1:0] LatchLoad = TW'(LATCH_CYCLES - 1);
    localparam logic [TW-1:0] HalfLoad  = TW'(HALF_CYCLES - 1);
    localparam logic [PW-1:0] PollLoad  = PW'(POLL_CYCLES - 1);

    if (POLL_CYCLES <= LATCH_CYCLES + 15 * HALF_CYCLES + 1) begin : g_bad_poll
        $error("POLL_CYCLES must exceed the frame length");
    end

    n8_state_t   state_q;
    logic [TW-1:0] timer_q;
    logic [PW-1:0] poll_q;
    logic [2:0]  bit_q;
    logic [7:0]  raw_q;
    logic [7:0]  prev_q;
    logic [7:0]  buttons_q;
    logic [7:0]  press_q;
    logic        latch_q;
    logic        pulse_q;
    logic        fd_q;
    logic        data_s;

    sync2 u_sync2 (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (data_in),
        .q_o     (data_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            poll_q    <= '0;
            bit_q     <= '0;
            raw_q     <= '0;
            prev_q    <= '0;
            buttons_q <= '0;
            press_q   <= '0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            press_q <= '0;
            fd_q    <= 1'b0;
            // Saturates at zero; only a frame start reloads it.
            if (poll_q != '0) begin
                poll_q <= poll_q - 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (poll_q == '0) begin
                        state_q <= LATCH;
                        latch_q <= 1'b1;
                        timer_q <= LatchLoad;
                        poll_q  <= PollLoad;
                    end
                end
                LATCH: begin
                    if (timer_q == '0) begin
                        state_q <= READ;
                        latch_q <= 1'b0;
                        pulse_q <= 1'b0;
                        bit_q   <= '0;
                        timer_q <= HalfLoad;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                READ: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else if (pulse_q) begin
                        pulse_q <= 1'b0;
                        timer_q <= HalfLoad;
                    end else begin
                        // Bit 0 enters first at the top and ends up in raw[0].
                        raw_q <= {~data_s, raw_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= DONE;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            pulse_q <= 1'b1;
                            timer_q <= HalfLoad;
                        end
                    end
                end
                DONE: begin
                    if (raw_q == prev_q) begin
                        buttons_q <= raw_q;
                        press_q   <= raw_q & ~buttons_q;
                    end
                    prev_q  <= raw_q;
                    fd_q    <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign latch      = latch_q;
    assign pulse      = pulse_q;
    assign buttons    = buttons_q;
    assign press      = press_q;
    assign frame_done = fd_q;
    assign up         = press_q[BTN_UP];
    assign down       = press_q[BTN_DOWN];
    assign select     = press_q[BTN_SELECT];
    assign start      = press_q[BTN_START];

endmodule

// File: tb/tb_n8_pad_reader.sv
// Bench for n8_pad_reader: behavioural pad model plus frame-level debounce reference.
module tb_n8_pad_reader;

    localparam int unsigned LC = 4;
    localparam int unsigned HC = 2;
    localparam int unsigned PC = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_in;
    logic       latch;
    logic       pulse;
    logic [7:0] buttons;
    logic [7:0] press;
    logic       up;
    logic       down;
    logic       select;
    logic       start;
    logic       frame_done;

    int tests = 0;
    int fails = 0;

    n8_pad_reader #(
        .LATCH_CYCLES (LC),
        .HALF_CYCLES  (HC),
        .POLL_CYCLES  (PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .latch      (latch),
        .pulse      (pulse),
        .buttons    (buttons),
        .press      (press),
        .up         (up),
        .down       (down),
        .select     (select),
        .start      (start),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Pad: parallel load while latch is high, shift on pulse rising edge, inverted output.
    logic [7:0] pad = '0;
    logic [7:0] sr = '0;
    logic       pulse_prev = 1'b0;

    always @(posedge clk) begin
        pulse_prev <= pulse;
        if (latch) sr <= pad;
        else if (pulse && !pulse_prev) sr <= {1'b0, sr[7:1]};
    end

    assign data_in = ~sr[0];

    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            assert (!(latch && pulse)) else begin
                fails++;
                $error("FAIL latch_pulse_overlap: latch=%0b pulse=%0b required not both", latch, pulse);
            end
            tests++;
            assert (press == 8'h00 || frame_done) else begin
                fails++;
                $error("FAIL press_without_fd: press=%h frame_done=%0b", press, frame_done);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: debounce rule applied per whole frame.
    logic [7:0] m_btn = '0;
    logic [7:0] m_prev = '0;

    task automatic run_frame(input logic [7:0] pat, input string tag);
        int n;
        logic [7:0] exp_press;
        pad = pat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        chk({tag, "_fd_seen"}, {31'd0, frame_done}, 32'd1);
        if (pat == m_prev) begin
            exp_press = pat & ~m_btn;
            m_btn = pat;
        end else begin
            exp_press = 8'h00;
        end
        m_prev = pat;
        chk({tag, "_buttons"}, {24'd0, buttons}, {24'd0, m_btn});
        chk({tag, "_press"}, {24'd0, press}, {24'd0, exp_press});
        chk({tag, "_up"}, {31'd0, up}, {31'd0, exp_press[4]});
        chk({tag, "_down"}, {31'd0, down}, {31'd0, exp_press[5]});
        chk({tag, "_select"}, {31'd0, select}, {31'd0, exp_press[2]});
        chk({tag, "_start"}, {31'd0, start}, {31'd0, exp_press[3]});
        @(negedge clk);
        chk({tag, "_press_1cyc"}, {24'd0, press}, 32'd0);
        chk({tag, "_fd_1cyc"}, {31'd0, frame_done}, 32'd0);
    endtask

    logic [69:0] lh, ph, fh, le, pe, fe;
    logic [7:0]  cur;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_latch", {31'd0, latch}, 32'd0);
        chk("reset_pulse", {31'd0, pulse}, 32'd0);
        chk("reset_buttons", {24'd0, buttons}, 32'd0);
        chk("reset_press", {24'd0, press}, 32'd0);
        chk("reset_fd", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;

        // Cycle 0 is the first cycle with reset sampled low at its closing edge.
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            lh[i] = latch;
            ph[i] = pulse;
            fh[i] = frame_done;
        end
        for (int i = 0; i < 70; i++) begin
            le[i] = (i >= 1 && i <= 4) || (i >= 65 && i <= 68);
            pe[i] = 1'b0;
            fe[i] = (i == 36);
        end
        for (int k = 1; k <= 7; k++) begin
            pe[7 + 4 * (k - 1)] = 1'b1;
            pe[8 + 4 * (k - 1)] = 1'b1;
        end
        tests++;
        assert (lh === le) else begin
            fails++;
            $error("FAIL timing_latch: observed %h expected %h", lh, le);
        end
        tests++;
        assert (ph === pe) else begin
            fails++;
            $error("FAIL timing_pulse: observed %h expected %h", ph, pe);
        end
        tests++;
        assert (fh === fe) else begin
            fails++;
            $error("FAIL timing_fd: observed %h expected %h", fh, fe);
        end
        chk("timing_pulse_cycles", $countones(ph), 32'd14);
        chk("timing_buttons", {24'd0, buttons}, 32'd0);

        run_frame(8'h00, "f2_idle");
        run_frame(8'h10, "up1");
        run_frame(8'h10, "up2");
        run_frame(8'h10, "up3");
        run_frame(8'hA5, "ord1");
        run_frame(8'hA5, "ord2");
        chk("ord_buttons", {24'd0, buttons}, 32'h0000_00A5);
        run_frame(8'h00, "rel1");
        run_frame(8'h00, "rel2");
        run_frame(8'h10, "gup1");
        run_frame(8'h10, "gup2");
        run_frame(8'h00, "gidle1");
        run_frame(8'h08, "gstart");
        run_frame(8'h00, "gidle2");
        run_frame(8'h00, "gidle3");
        chk("glitch_buttons", {24'd0, buttons}, 32'd0);
        run_frame(8'hFF, "all1");
        run_frame(8'hFF, "all2");

        cur = 8'h00;
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(0, 2) == 0) cur = 8'($urandom);
            run_frame(cur, "rand");
        end

        run_frame(8'hA5, "pre_rst1");
        run_frame(8'hA5, "pre_rst2");
        pad = 8'h81;
        begin
            int n;
            int r;
            logic pp;
            n = 0;
            while (!latch && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("rst_latch_seen", {31'd0, latch}, 32'd1);
            r = 0;
            pp = 1'b0;
            n = 0;
            while (r < 3 && n < 200) begin
                @(negedge clk);
                n++;
                if (pulse && !pp) r++;
                pp = pulse;
            end
            chk("rst_bit3_reached", r, 32'd3);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_latch", {31'd0, latch}, 32'd0);
        chk("rst_pulse", {31'd0, pulse}, 32'd0);
        chk("rst_buttons", {24'd0, buttons}, 32'd0);
        chk("rst_press", {24'd0, press}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_fd", {31'd0, frame_done}, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_btn = '0;
        m_prev = '0;
        @(negedge clk);
        chk("rst_c0_latch", {31'd0, latch}, 32'd0);
        chk("rst_c0_fd", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        chk("rst_c1_latch", {31'd0, latch}, 32'd1);
        run_frame(8'h81, "post1");
        run_frame(8'h81, "post2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
